decode_pipe: RTL and testbench
==============================

DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter XLEN, default 32, meaning datapath width of the immediate output; SHALL accept 32 or 64.
REQ-002 Parameter PC_W, default 32, meaning width of the program-counter sideband carried with each instruction.
REQ-003 Port clk  input  1  meaning the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  meaning reset; asynchronous assertion, active-low.
REQ-005 Port flush  input  1  meaning discard all buffered entries and any same-cycle input.
REQ-006 Port in_valid / in_ready  input / output  1 / 1  meaning upstream handshake; transfer when both are high.
REQ-007 Port in_instr / in_pc  input  32 / PC_W  meaning the raw instruction and its PC.
REQ-008 Port out_valid / out_ready  output / input  1 / 1  meaning downstream handshake; transfer when both are high.
REQ-009 Ports out_pc[PC_W], rs1_addr[5], rs2_addr[5], rd_addr[5], opcode[7], funct3[3], funct7[7]  output  meaning the decoded fields of the head entry.
REQ-010 Ports r_type, i_type, s_type, b_type, u_type, j_type, illegal  output  1 each  meaning format class flags; immediate  output  XLEN  meaning sign-extended immediate.

Function
REQ-011 Buffer: 2-entry FIFO holding decoded results, not raw instructions; decode SHALL be done at write time.
REQ-012 in_ready SHALL equal (entries < 2), driven from a register; no combinational path from out_ready.
REQ-013 Latency: an instruction accepted in cycle N SHALL appear with out_valid=1 in cycle N+1 when the buffer was empty.
REQ-014 out_valid SHALL equal (entries > 0); outputs SHALL show the oldest entry and hold stable while out_valid=1 and out_ready=0.
REQ-015 Simultaneous push and pop SHALL keep the count unchanged; with the buffer full, a pop SHALL raise in_ready in the next cycle.
REQ-016 Order SHALL be strictly FIFO; no entry is dropped or duplicated except by flush.
REQ-017 Field extraction: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7], opcode=instr[6:0], funct3=instr[14:12], funct7=instr[31:25], all passed raw for every class.
REQ-018 Class map: 0110011=R; 0000011, 0010011, 1100111, 0001111, 1110011=I; 0100011=S; 1100011=B; 0110111, 0010111=U; 1101111=J.
REQ-019 illegal=1 when instr[1:0]!=2'b11 or the opcode is not in REQ-018; then all six class flags=0 and immediate=0.
REQ-020 Exactly one class flag SHALL be high for a legal entry.
REQ-021 Immediate: I={instr[31:20]}; S={instr[31:25],instr[11:7]}; B={instr[31],instr[7],instr[30:25],instr[11:8],0}; J={instr[31],instr[19:12],instr[20],instr[30:21],0}; each sign-extended from instr[31] to XLEN.
REQ-022 Immediate: U={instr[31:12],12'b0} sign-extended to XLEN; R-type immediate=0.
REQ-023 flush SHALL empty the buffer in the next cycle, taking priority over the same-cycle push and pop; in_ready=1 and out_valid=0 in the following cycle.
REQ-024 No in_instr value, including 0x00000000 and 0xFFFFFFFF, SHALL cause a hang; illegal entries flow through the handshake like legal ones.

Reset
REQ-025 While rst_n=0: entries=0, out_valid=0, in_ready=1, and all data outputs and pointers=0.
REQ-026 Reset asserted mid-transfer SHALL discard all entries immediately; the first edge after release SHALL accept new input normally.

Verification
REQ-027 addi x1,x0,5 (0x00500093), pc 0x100, out_ready=1 -> next cycle: out_valid=1, i_type=1, rd=1, rs1=0, immediate=0x00000005, out_pc=0x100.
REQ-028 beq x0,x0,-4 (0xFE000EE3) -> b_type=1, immediate=0xFFFFFFFC; at XLEN=64 -> 0xFFFFFFFFFFFFFFFC.
REQ-029 lui x5,0x12345 (0x123452B7) at XLEN=64 -> u_type=1, rd=5, immediate=0x0000000012345000.
REQ-030 out_ready=0, push A, B, C on consecutive cycles -> in_ready=0 after B; C is not accepted until out_ready=1; outputs A then B then C, each exactly once.
REQ-031 Push 0x00000000 -> illegal=1, all class flags 0, immediate=0; then flush with two entries plus in_valid=1 -> next cycle out_valid=0, in_ready=1, and the same-cycle input is absent.
REQ-032 Drop rst_n with 2 entries buffered -> out_valid=0 and in_ready=1 immediately; after release, a new push appears 1 cycle later.

Source files
------------

// File: rtl/decode_pipe.sv
// decode_pipe: RV32 instruction decoder sitting in front of a 2-entry output
// FIFO. Instructions are decoded on the way in, so each FIFO slot holds
// decoded fields, class flags and the sign-extended immediate.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                drop all buffered entries and any same-cycle input
//   in_valid/in_ready    upstream handshake; in_ready is a register (count<2)
//   in_instr, in_pc      raw instruction and its PC
//   out_valid/out_ready  downstream handshake; out_valid is a register (count>0)
//   out_pc .. funct7     raw fields of the head (oldest) entry
//   r/i/s/b/u/j_type     format class flags, illegal flag
//   immediate            sign-extended immediate (XLEN bits)
module decode_pipe #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic            r_type,
    output logic            i_type,
    output logic            s_type,
    output logic            b_type,
    output logic            u_type,
    output logic            j_type,
    output logic            illegal,
    output logic [XLEN-1:0] immediate
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opc;
        logic [2:0]      f3;
        logic [6:0]      f7;
        logic            r, i, s, b, u, j, ill;
        logic [XLEN-1:0] imm;
    } dec_t;

    dec_t        dec;
    logic [31:0] imm32;

    // ---------------- decode (write side) ----------------
    always_comb begin
        dec     = '0;
        imm32   = '0;
        dec.pc  = in_pc;
        dec.rs1 = in_instr[19:15];
        dec.rs2 = in_instr[24:20];
        dec.rd  = in_instr[11:7];
        dec.opc = in_instr[6:0];
        dec.f3  = in_instr[14:12];
        dec.f7  = in_instr[31:25];

        case (in_instr[6:0])
            7'b0110011: dec.r = 1'b1;
            7'b0000011, 7'b0010011, 7'b1100111,
            7'b0001111, 7'b1110011: dec.i = 1'b1;
            7'b0100011: dec.s = 1'b1;
            7'b1100011: dec.b = 1'b1;
            7'b0110111, 7'b0010111: dec.u = 1'b1;
            7'b1101111: dec.j = 1'b1;
            default:    dec.ill = 1'b1;
        endcase

        // Compressed/non-32-bit encodings are illegal regardless of opcode.
        if (in_instr[1:0] != 2'b11) begin
            dec.ill = 1'b1;
            dec.r = 1'b0; dec.i = 1'b0; dec.s = 1'b0;
            dec.b = 1'b0; dec.u = 1'b0; dec.j = 1'b0;
        end

        if (dec.i)
            imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        else if (dec.s)
            imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        else if (dec.b)
            imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                     in_instr[30:25], in_instr[11:8], 1'b0};
        else if (dec.u)
            imm32 = {in_instr[31:12], 12'b0};
        else if (dec.j)
            imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};

        // 32-bit result is already sign-correct; widen with sign extension.
        dec.imm = XLEN'($signed(imm32));
    end

    // ---------------- 2-entry FIFO ----------------
    dec_t       mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       in_ready_q, out_valid_q;
    logic       push, pop;

    // Flush suppresses both sides so nothing moves in a flush cycle.
    assign push = in_valid  & in_ready_q  & ~flush;
    assign pop  = out_valid_q & out_ready & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            cnt_d = cnt_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            mem_q[0]    <= '0;
            mem_q[1]    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            // Handshake flags precomputed from next count to keep them registered.
            in_ready_q  <= (cnt_d != 2'd2);
            out_valid_q <= (cnt_d != 2'd0);
            if (push) mem_q[wr_ptr_q] <= dec;
        end
    end

    dec_t head;
    assign head = mem_q[rd_ptr_q];

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_pc    = head.pc;
    assign rs1_addr  = head.rs1;
    assign rs2_addr  = head.rs2;
    assign rd_addr   = head.rd;
    assign opcode    = head.opc;
    assign funct3    = head.f3;
    assign funct7    = head.f7;
    assign r_type    = head.r;
    assign i_type    = head.i;
    assign s_type    = head.s;
    assign b_type    = head.b;
    assign u_type    = head.u;
    assign j_type    = head.j;
    assign illegal   = head.ill;
    assign immediate = head.imm;

endmodule

// File: tb/tb_decode_pipe.sv
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [31:0] out_pc;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        r_type, i_type, s_type, b_type, u_type, j_type, illegal;
    logic [31:0] immediate;

    logic        in_ready64, out_valid64;
    logic [31:0] out_pc64;
    logic [4:0]  rs1_64, rs2_64, rd_64;
    logic [6:0]  opcode64, funct7_64;
    logic [2:0]  funct3_64;
    logic        r64, i64, s64, b64, u64, j64, ill64;
    logic [63:0] immediate64;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decode_pipe #(.XLEN(32), .PC_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rd_addr(rd_addr), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .r_type(r_type), .i_type(i_type), .s_type(s_type), .b_type(b_type),
        .u_type(u_type), .j_type(j_type), .illegal(illegal),
        .immediate(immediate)
    );

    decode_pipe #(.XLEN(64), .PC_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_pc(out_pc64), .rs1_addr(rs1_64), .rs2_addr(rs2_64),
        .rd_addr(rd_64), .opcode(opcode64), .funct3(funct3_64), .funct7(funct7_64),
        .r_type(r64), .i_type(i64), .s_type(s64), .b_type(b64),
        .u_type(u64), .j_type(j64), .illegal(ill64),
        .immediate(immediate64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
    endtask

    // Packs the six class flags + illegal as {r,i,s,b,u,j,ill}.
    function automatic logic [6:0] flags();
        return {r_type, i_type, s_type, b_type, u_type, j_type, illegal};
    endfunction

    initial begin
        // ---- reset state ----
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_imm", immediate, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_flags", flags(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // ---- addi x1,x0,5 ----
        drive(1, 32'h0050_0093, 32'h100);
        tick();
        chk("addi_valid", out_valid, 1);
        chk("addi_flags", flags(), 7'b0100000);
        chk("addi_rd", rd_addr, 1);
        chk("addi_rs1", rs1_addr, 0);
        chk("addi_imm", immediate, 32'h5);
        chk("addi_pc", out_pc, 32'h100);

        // ---- beq x0,x0,-4 ----
        drive(1, 32'hFE00_0EE3, 32'h104);
        tick();
        chk("beq_flags", flags(), 7'b0001000);
        chk("beq_imm32", immediate, 32'hFFFF_FFFC);
        chk("beq_imm64", immediate64, 64'hFFFF_FFFF_FFFF_FFFC);

        // ---- lui x5,0x12345 ----
        drive(1, 32'h1234_52B7, 32'h108);
        tick();
        chk("lui_flags", flags(), 7'b0000100);
        chk("lui_rd", rd_addr, 5);
        chk("lui_imm32", immediate, 32'h1234_5000);
        chk("lui_imm64", immediate64, 64'h0000_0000_1234_5000);

        // ---- sw x2,8(x1) ----
        drive(1, 32'h0020_A423, 32'h10C);
        tick();
        chk("sw_flags", flags(), 7'b0010000);
        chk("sw_imm", immediate, 32'h8);
        chk("sw_rs1_rs2", {rs1_addr, rs2_addr}, {5'd1, 5'd2});
        chk("sw_funct3", funct3, 3'b010);

        // ---- jal x0,-8 ----
        drive(1, 32'hFF9F_F06F, 32'h110);
        tick();
        chk("jal_flags", flags(), 7'b0000010);
        chk("jal_imm64", immediate64, 64'hFFFF_FFFF_FFFF_FFF8);

        // ---- add x3,x1,x2 ----
        drive(1, 32'h0020_81B3, 32'h114);
        tick();
        chk("add_flags", flags(), 7'b1000000);
        chk("add_imm", immediate, 0);
        chk("add_rd", rd_addr, 3);

        // ---- all-ones: illegal opcode, fields still raw ----
        drive(1, 32'hFFFF_FFFF, 32'h118);
        tick();
        chk("ones_flags", flags(), 7'b0000001);
        chk("ones_imm", immediate64, 0);
        chk("ones_funct7", funct7, 7'h7F);
        drive(0, 0, 0);
        tick();
        chk("drain_valid", out_valid, 0);

        // ---- backpressure A,B,C ----
        out_ready = 1'b0;
        drive(1, 32'h0050_0093, 32'h200);
        tick();
        chk("bp_ready_after_A", in_ready, 1);
        drive(1, 32'h0050_0093, 32'h204);
        tick();
        chk("bp_ready_after_B", in_ready, 0);
        drive(1, 32'h0050_0093, 32'h208);
        tick();
        chk("bp_C_blocked", in_ready, 0);
        chk("bp_head_A_hold", out_pc, 32'h200);
        out_ready = 1'b1;
        tick();                       // pop A, C still blocked
        chk("bp_head_B", out_pc, 32'h204);
        chk("bp_ready_after_pop", in_ready, 1);
        tick();                       // pop B, push C
        chk("bp_head_C", out_pc, 32'h208);
        chk("bp_valid_C", out_valid, 1);
        drive(0, 0, 0);
        tick();                       // pop C
        chk("bp_empty", out_valid, 0);

        // ---- all-zero instruction + flush with full buffer ----
        out_ready = 1'b0;
        drive(1, 32'h0000_0000, 32'h300);
        tick();
        chk("zero_flags", flags(), 7'b0000001);
        chk("zero_imm", immediate, 0);
        drive(1, 32'h0050_0093, 32'h304);
        tick();
        chk("fl_full", in_ready, 0);
        flush = 1'b1;
        drive(1, 32'h0050_0093, 32'h308);
        tick();
        flush = 1'b0;
        drive(0, 0, 0);
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        // flush with one entry while in_ready=1: the input must vanish too
        drive(1, 32'h0050_0093, 32'h30C);
        tick();
        flush = 1'b1;
        drive(1, 32'h0050_0093, 32'h310);
        tick();
        flush = 1'b0;
        drive(0, 0, 0);
        chk("fl1_valid", out_valid, 0);
        tick();
        chk("fl1_input_absent", out_valid, 0);

        // ---- reset mid-transfer with 2 entries ----
        drive(1, 32'h0050_0093, 32'h400);
        tick();
        drive(1, 32'h0050_0093, 32'h404);
        tick();
        drive(0, 0, 0);
        chk("rst2_full", in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_valid", out_valid, 0);
        chk("rst2_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1, 32'h1234_52B7, 32'h500);
        tick();
        drive(0, 0, 0);
        chk("rst2_new_valid", out_valid, 1);
        chk("rst2_new_pc", out_pc, 32'h500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
